coe_sram_writer: RTL and testbench



---
 rtl/coe_wr_pkg.sv | 30 +++
 rtl/coe_sram_writer_if.sv | 29 ++
 rtl/coe_encode.sv | 30 +++
 rtl/coe_sram_writer.sv | 192 +++++++++++++++++++
 tb/tb_coe_sram_writer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coe_wr_pkg.sv
// coe_wr_pkg
// Shared constants and FSM encoding for the coefficient SRAM writer.
// Table geometry: word address = SRAM_COE_BASE + (row << ROW_SHIFT) + col.
// Sign-magnitude format: positive words stay below 0xF000, negative words
// carry NEG_TAG in the top nibble and a saturated 12-bit magnitude below it.
// Optional macro COE_WR_VERIFY_EN adds the readback states RD_SETUP/RD_WAIT.
package coe_wr_pkg;

  localparam logic [17:0] SRAM_COE_BASE = 18'h10000;
  localparam int unsigned ROW_SHIFT     = 9;
  localparam int unsigned MAX_COLS      = 512;
  localparam logic [3:0]  NEG_TAG       = 4'hF;
  localparam logic [15:0] POS_SAT       = 16'hEFFF;
  localparam logic [11:0] NEG_MAG_SAT   = 12'hFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
`ifdef COE_WR_VERIFY_EN
    ST_RD_SETUP,
    ST_RD_WAIT,
`endif
    ST_NEXT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/coe_sram_writer_if.sv
// coe_sram_writer_if
// Bundles the coefficient stream handshake and the SRAM bus of the writer.
//   i_coe_valid/i_coe_data/o_coe_ready : coefficient stream (valid/ready)
//   o_sram_addr/o_sram_wdata           : SRAM word address and write data
//   o_sram_wr_en/o_sram_rd_en          : SRAM write / read strobes
//   i_sram_rdata                       : SRAM read data (readback only)
// Modport master is the writer's view; slave is the host + SRAM side.
interface coe_sram_writer_if;

  logic        i_coe_valid;
  logic [15:0] i_coe_data;
  logic        o_coe_ready;
  logic [17:0] o_sram_addr;
  logic [15:0] o_sram_wdata;
  logic        o_sram_wr_en;
  logic        o_sram_rd_en;
  logic [15:0] i_sram_rdata;

  modport master (
    input  i_coe_valid, i_coe_data, i_sram_rdata,
    output o_coe_ready, o_sram_addr, o_sram_wdata, o_sram_wr_en, o_sram_rd_en
  );

  modport slave (
    output i_coe_valid, i_coe_data, i_sram_rdata,
    input  o_coe_ready, o_sram_addr, o_sram_wdata, o_sram_wr_en, o_sram_rd_en
  );

endinterface

// File: rtl/coe_encode.sv
// coe_encode
// Combinational conversion of a signed two's-complement coefficient into the
// table's saturated sign-magnitude word.
//   coe_i     : signed 16-bit coefficient
//   enc_o     : encoded table word
//   is_zero_o : encoded word equals 0 (reader treats it as an invalid entry)
module coe_encode
  import coe_wr_pkg::*;
(
  input  logic [15:0] coe_i,
  output logic [15:0] enc_o,
  output logic        is_zero_o
);

  logic [16:0] negMag;

  always_comb begin
    // Negation done 17 bits wide so -32768 yields +32768 rather than wrapping.
    negMag = 17'd0 - {coe_i[15], coe_i};
    if (!coe_i[15]) begin
      enc_o = (coe_i > POS_SAT) ? POS_SAT : coe_i;
    end else if (negMag > {5'd0, NEG_MAG_SAT}) begin
      enc_o = {NEG_TAG, NEG_MAG_SAT};
    end else begin
      enc_o = {NEG_TAG, negMag[11:0]};
    end
    is_zero_o = (enc_o == 16'd0);
  end

endmodule

// File: rtl/coe_sram_writer.sv
// coe_sram_writer
// One-shot loader of the range-calibration coefficient table into SRAM.
// Each accepted coefficient is encoded and written to
// SRAM_COE_BASE + (row << 9) + col, columns first, then rows.
// Ports:
//   i_clk_50m, i_rst          : clock, synchronous active-high reset
//   i_load_start              : one-cycle session start pulse
//   i_row_num, i_col_num      : table dimensions (cols clamped to 512)
//   bus (master)              : coefficient stream + SRAM bus
//   o_load_busy, o_load_done  : session in progress / end-of-session pulse
//   o_zero_cnt                : encoded zero words this session (saturating)
//   o_load_err                : sticky readback mismatch flag
// Macro COE_WR_VERIFY_EN enables readback-compare after every write; without
// it o_sram_rd_en and o_load_err are tied low.
module coe_sram_writer #(
  parameter logic [17:0] SRAM_COE_BASE = coe_wr_pkg::SRAM_COE_BASE,
  parameter int unsigned WR_PULSE      = 2,
  parameter int unsigned RD_LAT        = 2
) (
  input  logic               i_clk_50m,
  input  logic               i_rst,
  input  logic               i_load_start,
  input  logic [7:0]         i_row_num,
  input  logic [9:0]         i_col_num,
  coe_sram_writer_if.master  bus,
  output logic               o_load_busy,
  output logic               o_load_done,
  output logic [15:0]        o_zero_cnt,
  output logic               o_load_err
);

  import coe_wr_pkg::*;

  state_e      state_q, state_d;
  logic [7:0]  rows_q, rows_d, row_q, row_d;
  logic [9:0]  cols_q, cols_d, col_q, col_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] zeroCnt_q, zeroCnt_d;
  logic        err_q, err_d;
  logic [15:0] encWord;
  logic        encZero;
  logic [17:0] wordAddr;
  logic        rdEn;

  coe_encode u_encode (
    .coe_i     (bus.i_coe_data),
    .enc_o     (encWord),
    .is_zero_o (encZero)
  );

  // 18-bit sum: the table address wraps rather than overflowing.
  assign wordAddr = SRAM_COE_BASE + (18'(row_q) << ROW_SHIFT) + 18'(col_q);

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      zeroCnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      zeroCnt_q <= zeroCnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rows_d          = rows_q;
    cols_d          = cols_q;
    row_d           = row_q;
    col_d           = col_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    zeroCnt_d       = zeroCnt_q;
    err_d           = err_q;
    bus.o_coe_ready = 1'b0;
    bus.o_sram_wr_en = 1'b0;
    rdEn            = 1'b0;
    o_load_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d  = '0;
        wdata_d = '0;
        if (i_load_start) begin
          rows_d    = i_row_num;
          cols_d    = (i_col_num > 10'(MAX_COLS)) ? 10'(MAX_COLS) : i_col_num;
          row_d     = '0;
          col_d     = '0;
          cnt_d     = '0;
          zeroCnt_d = '0;
          err_d     = 1'b0;
          state_d   = (i_row_num == 8'd0 || i_col_num == 10'd0) ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        bus.o_coe_ready = 1'b1;
        if (bus.i_coe_valid) begin
          wdata_d = encWord;
          addr_d  = wordAddr;
          if (encZero && zeroCnt_q != 16'hFFFF) begin
            zeroCnt_d = zeroCnt_q + 16'd1;
          end
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_WRITE;
      ST_WRITE: begin
        bus.o_sram_wr_en = 1'b1;
        if (cnt_q == 4'(WR_PULSE - 1)) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`ifdef COE_WR_VERIFY_EN
      ST_HOLD:     state_d = ST_RD_SETUP;
      ST_RD_SETUP: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        rdEn = 1'b1;
        if (cnt_q == 4'(RD_LAT - 1)) begin
          cnt_d = '0;
          if (bus.i_sram_rdata != wdata_q) begin
            err_d = 1'b1;
          end
          state_d = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`else
      ST_HOLD: state_d = ST_NEXT;
`endif
      ST_NEXT: begin
        if (row_q == rows_q - 8'd1 && col_q == cols_q - 10'd1) begin
          state_d = ST_DONE;
        end else begin
          if (col_q == cols_q - 10'd1) begin
            col_d = '0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 10'd1;
          end
          state_d = ST_ACCEPT;
        end
      end
      ST_DONE: begin
        o_load_done = 1'b1;
        addr_d      = '0;
        wdata_d     = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_sram_addr  = addr_q;
  assign bus.o_sram_wdata = wdata_q;
  assign o_load_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_zero_cnt       = zeroCnt_q;

`ifdef COE_WR_VERIFY_EN
  assign bus.o_sram_rd_en = rdEn;
  assign o_load_err       = err_q;
`else
  // Readback hardware is absent in this build; these taps only sink the inputs.
  localparam int unsigned unusedRdLat = RD_LAT;
  logic unusedVerify;
  assign unusedVerify     = rdEn | err_q | (^bus.i_sram_rdata);
  assign bus.o_sram_rd_en = 1'b0;
  assign o_load_err       = 1'b0;
`endif

endmodule

// File: tb/tb_coe_sram_writer.sv
// tb_coe_sram_writer
// Directed bench for coe_sram_writer with a simple SRAM model that corrupts
// bit 0 of the word read back from 0x10001. Build with COE_WR_VERIFY_EN to
// exercise the readback path.
module tb_coe_sram_writer;

  import coe_wr_pkg::*;

  localparam int unsigned WR_PULSE = 2;
  localparam int unsigned RD_LAT   = 2;

  logic        clock;
  logic        reset;
  logic        loadStart;
  logic [7:0]  rowNum;
  logic [9:0]  colNum;
  logic        loadBusy;
  logic        loadDone;
  logic [15:0] zeroCnt;
  logic        loadErr;

  coe_sram_writer_if bus ();

  coe_sram_writer #(
    .SRAM_COE_BASE (18'h10000),
    .WR_PULSE      (WR_PULSE),
    .RD_LAT        (RD_LAT)
  ) dut (
    .i_clk_50m    (clock),
    .i_rst        (reset),
    .i_load_start (loadStart),
    .i_row_num    (rowNum),
    .i_col_num    (colNum),
    .bus          (bus),
    .o_load_busy  (loadBusy),
    .o_load_done  (loadDone),
    .o_zero_cnt   (zeroCnt),
    .o_load_err   (loadErr)
  );

  int vecCnt  = 0;
  int missCnt = 0;

  // 50 MHz clock
  initial clock = 1'b0;
  always #10 clock = ~clock;

  // SRAM model: write on the strobe, read is asynchronous with bit 0 flipped at 0x10001
  logic [15:0] sramMem [0:262143];
  always @(posedge clock) begin
    if (bus.o_sram_wr_en) sramMem[bus.o_sram_addr] <= bus.o_sram_wdata;
  end
  assign bus.i_sram_rdata = sramMem[bus.o_sram_addr] ^ {15'd0, (bus.o_sram_addr == 18'h10001)};

  task automatic checkOutput(input string tag, input logic [31:0] obsVal, input logic [31:0] expVal);
    vecCnt++;
    assert (obsVal === expVal) else begin
      missCnt++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obsVal, expVal);
    end
  endtask

  // Write monitor: records each write and checks pulse width and bus stability
  logic [17:0] wAddrQ [$];
  logic [15:0] wDataQ [$];
  int          wrCnt = 0;
  int          pulseLen = 0;
  logic        wrPrev = 1'b0;
  logic        rdSeen = 1'b0;
  logic        pulseCheckEn = 1'b1;
  logic [17:0] addrPrev = '0;
  logic [17:0] riseAddr = '0;
  logic [15:0] riseData = '0;

  always @(negedge clock) begin
    if (bus.o_sram_wr_en && !wrPrev) begin
      wrCnt <= wrCnt + 1;
      wAddrQ.push_back(bus.o_sram_addr);
      wDataQ.push_back(bus.o_sram_wdata);
      riseAddr <= bus.o_sram_addr;
      riseData <= bus.o_sram_wdata;
      pulseLen <= 1;
      if (pulseCheckEn) checkOutput("setup addr stable", 32'(addrPrev), 32'(bus.o_sram_addr));
    end else if (bus.o_sram_wr_en) begin
      pulseLen <= pulseLen + 1;
    end else if (wrPrev && pulseCheckEn) begin
      checkOutput("wr pulse width", 32'(pulseLen), 32'(WR_PULSE));
      checkOutput("hold addr stable", 32'(bus.o_sram_addr), 32'(riseAddr));
      checkOutput("hold data stable", 32'(bus.o_sram_wdata), 32'(riseData));
    end
    if (bus.o_sram_rd_en) rdSeen <= 1'b1;
    wrPrev   <= bus.o_sram_wr_en;
    addrPrev <= bus.o_sram_addr;
  end

  task automatic applyStimulus(input logic [7:0] rows, input logic [9:0] cols);
    @(negedge clock);
    loadStart = 1'b1;
    rowNum    = rows;
    colNum    = cols;
    @(negedge clock);
    loadStart = 1'b0;
  endtask

  task automatic sendWord(input logic [15:0] d);
    bit accepted = 0;
    bus.i_coe_valid = 1'b1;
    bus.i_coe_data  = d;
    for (int i = 0; i < 200; i++) begin
      if (bus.o_coe_ready) begin
        @(posedge clock);
        accepted = 1;
        break;
      end
      @(negedge clock);
    end
    if (!accepted) checkOutput("handshake timeout", 32'd0, 32'd1);
    @(negedge clock);
    bus.i_coe_valid = 1'b0;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!bus.o_coe_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!bus.o_coe_ready) checkOutput("ready timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDone();
    int n = 0;
    while (!loadDone && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("done seen", 32'(loadDone), 32'd1);
  endtask

  task automatic clearWrites();
    wAddrQ.delete();
    wDataQ.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wrBase;
    reset           = 1'b1;
    loadStart       = 1'b0;
    rowNum          = '0;
    colNum          = '0;
    bus.i_coe_valid = 1'b0;
    bus.i_coe_data  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    checkOutput("reset busy", 32'(loadBusy), 32'd0);
    checkOutput("reset done", 32'(loadDone), 32'd0);
    checkOutput("reset addr", 32'(bus.o_sram_addr), 32'd0);
    checkOutput("reset wdata", 32'(bus.o_sram_wdata), 32'd0);
    checkOutput("reset ready", 32'(bus.o_coe_ready), 32'd0);
    checkOutput("reset zero cnt", 32'(zeroCnt), 32'd0);
    checkOutput("reset err", 32'(loadErr), 32'd0);

    // Encoder sweep, 1x4: -5, -5000, 20000, 32767. 32767 is below the
    // positive saturation limit 0xEFFF and so passes through as 0x7FFF.
    clearWrites();
    applyStimulus(8'd1, 10'd4);
    checkOutput("busy after start", 32'(loadBusy), 32'd1);
    sendWord(16'hFFFB);
    sendWord(16'hEC78);
    sendWord(16'h4E20);
    sendWord(16'h7FFF);
    waitDone();
    checkOutput("sweep busy at done", 32'(loadBusy), 32'd0);
    checkOutput("sweep write count", 32'(wDataQ.size()), 32'd4);
    if (wDataQ.size() == 4) begin
      checkOutput("enc -5", 32'(wDataQ[0]), 32'hF005);
      checkOutput("enc -5000", 32'(wDataQ[1]), 32'hFFFF);
      checkOutput("enc 20000", 32'(wDataQ[2]), 32'h4E20);
      checkOutput("enc 32767", 32'(wDataQ[3]), 32'h7FFF);
      checkOutput("sweep addr 3", 32'(wAddrQ[3]), 32'h10003);
    end
    @(negedge clock);
    checkOutput("idle addr zero", 32'(bus.o_sram_addr), 32'd0);
    checkOutput("idle wdata zero", 32'(bus.o_sram_wdata), 32'd0);

    // 2x2 row-major load
    clearWrites();
    applyStimulus(8'd2, 10'd2);
    sendWord(16'd1);
    sendWord(16'd2);
    sendWord(16'd3);
    sendWord(16'd4);
    waitDone();
    checkOutput("2x2 write count", 32'(wAddrQ.size()), 32'd4);
    if (wAddrQ.size() == 4) begin
      checkOutput("2x2 addr 0", 32'(wAddrQ[0]), 32'h10000);
      checkOutput("2x2 addr 1", 32'(wAddrQ[1]), 32'h10001);
      checkOutput("2x2 addr 2", 32'(wAddrQ[2]), 32'h10200);
      checkOutput("2x2 addr 3", 32'(wAddrQ[3]), 32'h10201);
      checkOutput("2x2 data 3", 32'(wDataQ[3]), 32'd4);
    end
    @(negedge clock);
    checkOutput("done one cycle", 32'(loadDone), 32'd0);

    // rows = 0: straight to DONE, no writes
    wrBase = wrCnt;
    applyStimulus(8'd0, 10'd5);
    checkOutput("rows0 done", 32'(loadDone), 32'd1);
    @(negedge clock);
    checkOutput("rows0 done drop", 32'(loadDone), 32'd0);
    checkOutput("rows0 no writes", 32'(wrCnt - wrBase), 32'd0);

    // cols = 600 clamps to 512
    clearWrites();
    applyStimulus(8'd1, 10'd600);
    for (int i = 0; i < 512; i++) sendWord(16'(i + 1));
    waitDone();
    checkOutput("clamp write count", 32'(wAddrQ.size()), 32'd512);
    if (wAddrQ.size() == 512) begin
      checkOutput("clamp last addr", 32'(wAddrQ[511]), 32'h101FF);
      checkOutput("clamp last data", 32'(wDataQ[511]), 32'h200);
    end

    // Zero counting, with a start pulse injected mid-session
    wrBase = wrCnt;
    applyStimulus(8'd1, 10'd3);
    sendWord(16'd0);
    loadStart = 1'b1;
    rowNum    = 8'd5;
    colNum    = 10'd5;
    @(negedge clock);
    loadStart = 1'b0;
    sendWord(16'd7);
    sendWord(16'd0);
    waitDone();
    checkOutput("zero cnt", 32'(zeroCnt), 32'd2);
    repeat (10) @(negedge clock);
    checkOutput("busy start ignored", 32'(loadBusy), 32'd0);
    checkOutput("zero test writes", 32'(wrCnt - wrBase), 32'd3);

    // Reset during WRITE of word 2
    applyStimulus(8'd2, 10'd2);
    sendWord(16'd10);
    sendWord(16'd20);
    @(negedge clock);
    checkOutput("in write", 32'(bus.o_sram_wr_en), 32'd1);
    pulseCheckEn = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst busy", 32'(loadBusy), 32'd0);
    checkOutput("rst wr_en", 32'(bus.o_sram_wr_en), 32'd0);
    checkOutput("rst addr", 32'(bus.o_sram_addr), 32'd0);
    checkOutput("rst wdata", 32'(bus.o_sram_wdata), 32'd0);
    checkOutput("rst zero cnt", 32'(zeroCnt), 32'd0);
    checkOutput("rst state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clock);
    pulseCheckEn = 1'b1;
    clearWrites();
    applyStimulus(8'd1, 10'd2);
    sendWord(16'h11);
    sendWord(16'h22);
    waitDone();
    checkOutput("post-rst write count", 32'(wAddrQ.size()), 32'd2);
    if (wAddrQ.size() == 2) begin
      checkOutput("post-rst addr 0", 32'(wAddrQ[0]), 32'h10000);
      checkOutput("post-rst data 0", 32'(wDataQ[0]), 32'h11);
    end

    // Readback session: the model corrupts the word at 0x10001
    applyStimulus(8'd1, 10'd3);
    sendWord(16'h100);
    waitReady();
    checkOutput("err after word 1", 32'(loadErr), 32'd0);
    sendWord(16'h101);
    waitReady();
`ifdef COE_WR_VERIFY_EN
    checkOutput("err after word 2", 32'(loadErr), 32'd1);
`else
    checkOutput("err after word 2", 32'(loadErr), 32'd0);
`endif
    sendWord(16'h102);
    waitDone();
`ifdef COE_WR_VERIFY_EN
    checkOutput("err at done", 32'(loadErr), 32'd1);
`else
    checkOutput("err at done", 32'(loadErr), 32'd0);
`endif
    applyStimulus(8'd1, 10'd1);
    checkOutput("err cleared on start", 32'(loadErr), 32'd0);
    sendWord(16'h5);
    waitDone();
`ifdef COE_WR_VERIFY_EN
    checkOutput("rd_en seen", 32'(rdSeen), 32'd1);
`else
    checkOutput("rd_en never high", 32'(rdSeen), 32'd0);
`endif

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
